dmem_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the single-port data memory (100 words, combinational read, write committed on rising clock edge). It sits between two requesters, client 0 (processor load/store path) and client 1 (debug/DMA loader), and the memory. It grants one access at a time, drives the memory control signals from registers, captures read data, and rejects out-of-range addresses without touching memory.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-client round-robin arbiter and access sequencer in front of a
//   single-port data memory (DEPTH words, combinational read, write committed
//   on the rising clock edge). One access is in flight at a time and walks
//   IDLE -> ACCESS -> DONE, so peak throughput is one access per 3 cycles.
//   Addresses >= DEPTH are rejected with err and never reach the memory as a
//   write.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/1, we0/1         request and write(1)/read(0) from client 0/1
//   addr0/1, wdata0/1     word address and write data, held with req
//   ack0/1, err0/1        one-cycle completion pulse, error flag with ack
//   rdata0/1              read data, valid while ack is high, otherwise held
//   mem_address           memory address (registered)
//   mem_write             memory write enable (registered, one cycle)
//   mem_data_in           memory write data (registered)
//   mem_data_out          memory combinational read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AD_WD   = 16,
  parameter int DATA_WD = 32,
  parameter int DEPTH   = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [AD_WD-1:0]   addr0,
  input  logic [AD_WD-1:0]   addr1,
  input  logic [DATA_WD-1:0] wdata0,
  input  logic [DATA_WD-1:0] wdata1,
  output logic               ack0,
  output logic               ack1,
  output logic               err0,
  output logic               err1,
  output logic [DATA_WD-1:0] rdata0,
  output logic [DATA_WD-1:0] rdata1,
  output logic [AD_WD-1:0]   mem_address,
  output logic               mem_write,
  output logic [DATA_WD-1:0] mem_data_in,
  input  logic [DATA_WD-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [AD_WD-1:0] DEPTH_A = AD_WD'(DEPTH);

  state_t state;
  logic   last_grant;   // client that won the most recent grant
  logic   cur_client;   // client owning the access in flight
  logic   cur_we;       // direction of the access in flight

  // Winner selection for a grant in IDLE.
  logic               grant;
  logic               sel_we;
  logic [AD_WD-1:0]   sel_addr;
  logic [DATA_WD-1:0] sel_wdata;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (req0 && req1) grant = ~last_grant;  // tie: whoever did not win last
    else if (req1)    grant = 1'b1;         // lone requester always wins
  end

  assign sel_we    = grant ? we1    : we0;
  assign sel_addr  = grant ? addr1  : addr0;
  assign sel_wdata = grant ? wdata1 : wdata0;

  // mem_address is stable for the whole access, so the range check in
  // ACCESS can be taken straight from the register.
  logic               out_of_range;
  logic [DATA_WD-1:0] rd_value;

  assign out_of_range = (mem_address >= DEPTH_A);
  assign rd_value     = (!cur_we && !out_of_range) ? mem_data_out : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_client  <= 1'b0;
      cur_we      <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            last_grant  <= grant;
            cur_client  <= grant;
            cur_we      <= sel_we;
            mem_address <= sel_addr;
            mem_data_in <= sel_wdata;
            // An out-of-range write must never strobe the memory.
            mem_write   <= sel_we && (sel_addr < DEPTH_A);
            state       <= ACCESS;
          end
        end

        ACCESS: begin
          mem_write <= 1'b0;
          if (cur_client) begin
            ack1   <= 1'b1;
            err1   <= out_of_range;
            rdata1 <= rd_value;
          end else begin
            ack0   <= 1'b1;
            err0   <= out_of_range;
            rdata0 <= rd_value;
          end
          state <= DONE;
        end

        DONE: begin
          // Requests are ignored here; a req still high is re-sampled in IDLE.
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed testbench for dmem_arbiter with a behavioural 100-word memory
//   attached to the memory port. Inputs change 1 time unit after a rising
//   edge; outputs are sampled at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AD_WD   = 16;
  localparam int DATA_WD = 32;
  localparam int DEPTH   = 100;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req0, req1, we0, we1;
  logic [AD_WD-1:0]   addr0, addr1;
  logic [DATA_WD-1:0] wdata0, wdata1;
  logic               ack0, ack1, err0, err1;
  logic [DATA_WD-1:0] rdata0, rdata1;
  logic [AD_WD-1:0]   mem_address;
  logic               mem_write;
  logic [DATA_WD-1:0] mem_data_in;
  logic [DATA_WD-1:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AD_WD(AD_WD), .DATA_WD(DATA_WD), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .ack0         (ack0),
    .ack1         (ack1),
    .err0         (err0),
    .err1         (err1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .mem_address  (mem_address),
    .mem_write    (mem_write),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Behavioural data memory: combinational read, write on rising edge.
  logic [DATA_WD-1:0] mem [0:DEPTH-1];
  logic               bad_write = 1'b0;   // any mem_write at an illegal address

  always_comb begin
    mem_data_out = '0;
    if (mem_address < AD_WD'(DEPTH)) mem_data_out = mem[mem_address];
  end

  always @(posedge clk) begin
    if (mem_write) begin
      if (mem_address < AD_WD'(DEPTH)) mem[mem_address] <= mem_data_in;
      else bad_write <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access from IDLE: request, grant edge, ack edge, return edge.
  task automatic do_access(input string tag, input bit c, input bit we,
                           input logic [AD_WD-1:0] a, input logic [DATA_WD-1:0] d,
                           input bit exp_mw, input bit exp_err,
                           input logic [DATA_WD-1:0] exp_rd);
    if (c) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    step();  // grant edge: ACCESS
    chk({tag, ".mem_write"}, mem_write, exp_mw);
    chk({tag, ".mem_address"}, mem_address, a);
    chk({tag, ".ack_early"}, c ? ack1 : ack0, 0);
    step();  // capture edge: DONE
    chk({tag, ".ack"}, c ? ack1 : ack0, 1);
    chk({tag, ".err"}, c ? err1 : err0, exp_err);
    chk({tag, ".rdata"}, c ? rdata1 : rdata0, exp_rd);
    chk({tag, ".other_ack"}, c ? ack0 : ack1, 0);
    chk({tag, ".mem_write_done"}, mem_write, 0);
    if (c) req1 = 1'b0; else req0 = 1'b0;
    step();  // back to IDLE
    chk({tag, ".ack_clear"}, c ? ack1 : ack0, 0);
    chk({tag, ".err_clear"}, c ? err1 : err0, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // ---------------- Reset values
    #12;
    chk("rst.ack0", ack0, 0);
    chk("rst.ack1", ack1, 0);
    chk("rst.err0", err0, 0);
    chk("rst.err1", err1, 0);
    chk("rst.rdata0", rdata0, 0);
    chk("rst.rdata1", rdata1, 0);
    chk("rst.mem_write", mem_write, 0);
    chk("rst.mem_address", mem_address, 0);
    chk("rst.mem_data_in", mem_data_in, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("idle.mem_write", mem_write, 0);
      chk("idle.ack0", ack0, 0);
      step();
    end

    // ---------------- Single write then read, client 0
    do_access("c0_wr5", 1'b0, 1'b1, 16'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    chk("c0_wr5.mem", mem[5], 32'hDEADBEEF);
    do_access("c0_rd5", 1'b0, 1'b0, 16'd5, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF);
    chk("c0.rdata1_untouched", rdata1, 0);

    // ---------------- Contention after reset: grants 0,1,0,1
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();
    req0 = 1; we0 = 1; addr0 = 16'd10; wdata0 = 32'hA0A0_0010;
    req1 = 1; we1 = 1; addr1 = 16'd11; wdata1 = 32'hB1B1_0011;
    for (int e = 0; e <= 10; e++) begin
      step();
      // Grant at edges 0,3,6,9; ack one edge after grant+1; owner alternates.
      chk($sformatf("cont.ack0.e%0d", e), ack0, (e == 1 || e == 7) ? 1 : 0);
      chk($sformatf("cont.ack1.e%0d", e), ack1, (e == 4 || e == 10) ? 1 : 0);
      chk($sformatf("cont.mw.e%0d", e), mem_write, (e % 3 == 0) ? 1 : 0);
    end
    req0 = 0; req1 = 0;
    step();
    chk("cont.mem10", mem[10], 32'hA0A0_0010);
    chk("cont.mem11", mem[11], 32'hB1B1_0011);

    // ---------------- Boundary, client 1
    do_access("c1_wr99", 1'b1, 1'b1, 16'd99, 32'h1, 1'b1, 1'b0, 32'h0);
    do_access("c1_rd99", 1'b1, 1'b0, 16'd99, 32'h0, 1'b0, 1'b0, 32'h1);
    do_access("c1_wr100", 1'b1, 1'b1, 16'd100, 32'h2, 1'b0, 1'b1, 32'h0);
    do_access("c1_rd99b", 1'b1, 1'b0, 16'd99, 32'h0, 1'b0, 1'b0, 32'h1);
    do_access("c1_wrFFFF", 1'b1, 1'b1, 16'hFFFF, 32'h3, 1'b0, 1'b1, 32'h0);
    do_access("c1_rd100", 1'b1, 1'b0, 16'd100, 32'h0, 1'b0, 1'b1, 32'h0);
    chk("bnd.mem99", mem[99], 32'h1);
    chk("bnd.bad_write", bad_write, 0);

    // ---------------- Held request: one access per 3-cycle window
    req0 = 1; we0 = 1; addr0 = 16'd20; wdata0 = 32'h55;
    for (int e = 0; e <= 7; e++) begin
      step();
      chk($sformatf("held.mw.e%0d", e), mem_write, (e % 3 == 0) ? 1 : 0);
      chk($sformatf("held.ack0.e%0d", e), ack0, (e % 3 == 1) ? 1 : 0);
    end
    req0 = 0;
    step();
    chk("held.idle_mw", mem_write, 0);
    chk("held.mem20", mem[20], 32'h55);

    // ---------------- Reset during ACCESS
    do_access("c0_wr7", 1'b0, 1'b1, 16'd7, 32'h77, 1'b1, 1'b0, 32'h0);
    req0 = 1; we0 = 1; addr0 = 16'd7; wdata0 = 32'hAA;
    step();
    chk("rstmid.mw_before", mem_write, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.mw_dropped", mem_write, 0);
    req0 = 0;
    step();
    chk("rstmid.no_ack0", ack0, 0);
    chk("rstmid.mem7", mem[7], 32'h77);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rstmid.no_ack0_after", ack0, 0);
    do_access("c0_rd7", 1'b0, 1'b0, 16'd7, 32'h0, 1'b0, 1'b0, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
